// File: rtl/tdm_demux4_if.sv
// tdm_demux4_if: serial beat input and parallel channel output bundle for tdm_demux4.
interface tdm_demux4_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             frame_sync;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic             sa;
  logic             sb;
  logic             frame_valid;
  logic             locked;
  logic             sync_err;
  logic [CNT_W-1:0] frame_cnt;
  modport master (
    output din, din_valid, frame_sync,
    input  a, b, c, d, sa, sb, frame_valid, locked, sync_err, frame_cnt
  );
  modport slave (
    input  din, din_valid, frame_sync,
    output a, b, c, d, sa, sb, frame_valid, locked, sync_err, frame_cnt
  );
endinterface

// File: rtl/tdm_demux4.sv
// tdm_demux4: four-slot TDM demultiplexer with hunt/lock frame alignment.
module tdm_demux4 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input logic         clk,
  input logic         rst_n,
  tdm_demux4_if.slave bus
);
  typedef enum logic {HUNT, LOCK} state_t;
  state_t           state;
  logic [1:0]       slot;
  logic [WIDTH-1:0] sh_a, sh_b, sh_c;
  logic [WIDTH-1:0] a, b, c, d;
  logic             frame_valid, sync_err;
  logic [CNT_W-1:0] frame_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= HUNT;
      slot        <= 2'd0;
      sh_a        <= '0;
      sh_b        <= '0;
      sh_c        <= '0;
      a           <= '0;
      b           <= '0;
      c           <= '0;
      d           <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (bus.din_valid) begin
        if (bus.frame_sync) begin
          // a marker always starts a fresh frame; it is only an error mid-frame
          sh_a     <= bus.din;
          slot     <= 2'd1;
          sync_err <= (state == LOCK) && (slot != 2'd0);
          state    <= LOCK;
        end else if (state == LOCK) begin
          if (slot == 2'd0) begin
            sync_err <= 1'b1;
            state    <= HUNT;
          end else if (slot == 2'd3) begin
            a           <= sh_a;
            b           <= sh_b;
            c           <= sh_c;
            d           <= bus.din;
            frame_valid <= 1'b1;
            frame_cnt   <= frame_cnt + CNT_W'(1);
            slot        <= 2'd0;
          end else begin
            if (slot == 2'd1) sh_b <= bus.din;
            else sh_c <= bus.din;
            slot <= slot + 2'd1;
          end
        end
      end
    end
  end
  assign bus.a           = a;
  assign bus.b           = b;
  assign bus.c           = c;
  assign bus.d           = d;
  assign bus.sa          = slot[1];
  assign bus.sb          = slot[0];
  assign bus.locked      = (state == LOCK);
  assign bus.frame_valid = frame_valid;
  assign bus.sync_err    = sync_err;
  assign bus.frame_cnt   = frame_cnt;
endmodule
